ladybird_bus_arbiter: RTL and testbench

LADYBIRD_BUS_ARBITER -- requirements
Module: ladybird_bus_arbiter

---
 rtl/ladybird_bus_arbiter_pkg.sv | 18 +
 rtl/ladybird_rr_picker.sv | 28 ++
 rtl/ladybird_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_ladybird_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_bus_arbiter_pkg.sv
// rtl/ladybird_bus_arbiter_pkg.sv - ladybird_config package: arbiter state and requester-id types
// Shared by ladybird_bus_arbiter and ladybird_rr_picker.
package ladybird_config;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_IFETCH = 1'b0;
  localparam req_id_t REQ_DATA   = 1'b1;

endpackage

// File: rtl/ladybird_rr_picker.sv
// rtl/ladybird_rr_picker.sv - two-requester picker, one-hot grant
// LADYBIRD_ARB_ROUND_ROBIN_EN: tie goes to ptr; otherwise m1 (data) wins every tie.
module ladybird_rr_picker
  import ladybird_config::*;
(
  input  logic       req0,
  input  logic       req1,
  input  req_id_t    ptr,
  output logic [1:0] gnt
);

`ifndef LADYBIRD_ARB_ROUND_ROBIN_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

  always_comb begin
    gnt = {req1, req0};
    if (req0 && req1) begin
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
      gnt = (ptr == REQ_DATA) ? 2'b10 : 2'b01;
`else
      gnt = 2'b10;
`endif
    end
  end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// rtl/ladybird_bus_arbiter.sv - two-master to one-bus arbiter, one transaction outstanding
// LADYBIRD_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; default is fixed priority.
module ladybird_bus_arbiter
  import ladybird_config::*;
#(
  parameter int XLEN = ladybird_config::XLEN
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic              m0_req,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  input  logic [XLEN/8-1:0] m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_data_gnt,
  output logic [XLEN-1:0]   m0_rdata,
  input  logic              m1_req,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  input  logic [XLEN/8-1:0] m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_data_gnt,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              bus_req,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_data_gnt,
  input  logic [XLEN-1:0]   bus_rdata
);

  arb_state_t        state_q, state_d;
  req_id_t           owner_q, owner_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN/8-1:0] wstrb_q, wstrb_d;
  req_id_t           ptr;
  logic [1:0]        pick;

  ladybird_rr_picker u_picker (
    .req0 (m0_req),
    .req1 (m1_req),
    .ptr  (ptr),
    .gnt  (pick)
  );

`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
  req_id_t ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = REQ_IFETCH;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          owner_d = pick[1] ? REQ_DATA : REQ_IFETCH;
          addr_d  = pick[1] ? m1_addr  : m0_addr;
          wdata_d = pick[1] ? m1_wdata : m0_wdata;
          wstrb_d = pick[1] ? m1_wstrb : m0_wstrb;
          state_d = ADDR;
        end
      end
      ADDR: if (bus_gnt) state_d = DATA;
      DATA: begin
        if (bus_data_gnt) begin
          state_d = IDLE;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
          // The requester just served loses the next tie.
          ptr_d   = ~owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (!nrst) begin
      state_d = IDLE;
      owner_d = REQ_IFETCH;
      addr_d  = '0;
      wdata_d = '0;
      wstrb_d = '0;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
      ptr_d   = REQ_IFETCH;
`endif
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q <= IDLE;
      owner_q <= REQ_IFETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
      ptr_q   <= REQ_IFETCH;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Pulses are only forwarded in the state that expects them; strays are dropped.
  always_comb begin
    bus_req     = (state_q == ADDR);
    bus_addr    = bus_req ? addr_q  : '0;
    bus_wdata   = bus_req ? wdata_q : '0;
    bus_wstrb   = bus_req ? wstrb_q : '0;
    m0_gnt      = bus_req && bus_gnt && (owner_q == REQ_IFETCH);
    m1_gnt      = bus_req && bus_gnt && (owner_q == REQ_DATA);
    m0_data_gnt = (state_q == DATA) && bus_data_gnt && (owner_q == REQ_IFETCH);
    m1_data_gnt = (state_q == DATA) && bus_data_gnt && (owner_q == REQ_DATA);
    m0_rdata    = m0_data_gnt ? bus_rdata : '0;
    m1_rdata    = m1_data_gnt ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb/tb_ladybird_bus_arbiter.sv - directed self-checking bench for ladybird_bus_arbiter
// Tie-order and starvation expectations follow LADYBIRD_ARB_ROUND_ROBIN_EN.
module tb_ladybird_bus_arbiter;

  logic        clk = 1'b0;
  logic        anrst, nrst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_data_gnt, m1_gnt, m1_data_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bus_req;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_data_gnt;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ladybird_bus_arbiter dut (
    .clk(clk), .anrst(anrst), .nrst(nrst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_data_gnt(m0_data_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_data_gnt(m1_data_gnt), .m1_rdata(m1_rdata),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_data_gnt(bus_data_gnt), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Acts as bus slave for one transaction and checks it lands on the expected owner.
  task automatic serve(input string tag, input logic owner, input logic [31:0] exp_addr,
                       input bit keep_req);
    int n;
    logic [31:0] rd;
    n = 0;
    @(negedge clk);
    while (bus_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_bus_req"}, 32'(bus_req), 32'd1);
    check({tag, "_addr"}, bus_addr, exp_addr);
    bus_gnt = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), owner ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    if (!keep_req) begin
      if (owner) m1_req = 1'b0;
      else       m0_req = 1'b0;
    end
    rd = ~exp_addr;
    bus_rdata    = rd;
    bus_data_gnt = 1'b1;
    #1;
    check({tag, "_data_gnt"}, 32'({m1_data_gnt, m0_data_gnt}), owner ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, owner ? m1_rdata : m0_rdata, rd);
    check({tag, "_other_rdata"}, owner ? m0_rdata : m1_rdata, 32'd0);
    @(posedge clk);
    #1;
    bus_data_gnt = 1'b0;
    bus_rdata    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    anrst = 1'b0; nrst = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    bus_gnt = 1'b0; bus_data_gnt = 1'b0; bus_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_gnts", 32'({m1_data_gnt, m1_gnt, m0_data_gnt, m0_gnt}), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    after_edge();
    anrst = 1'b1;
    @(negedge clk);
    check("rst_idle", 32'(bus_req), 32'd0);

    // m0 read 0x100, immediate bus_gnt, data_gnt two cycles later
    after_edge();
    m0_req = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hAAAA5555; m0_wstrb = 4'h0;
    @(negedge clk);
    check("t1_idle_bus_req", 32'(bus_req), 32'd0);
    after_edge();
    bus_gnt = 1'b1;
    @(negedge clk);
    check("t1_bus_req", 32'(bus_req), 32'd1);
    check("t1_bus_addr", bus_addr, 32'h100);
    check("t1_bus_wdata", bus_wdata, 32'hAAAA5555);
    check("t1_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("t1_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
    after_edge();
    bus_gnt = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    check("t1_data_bus_req", 32'(bus_req), 32'd0);
    check("t1_wait_data_gnt", 32'({m1_data_gnt, m0_data_gnt}), 32'd0);
    after_edge();
    bus_data_gnt = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_data_gnt", 32'({m1_data_gnt, m0_data_gnt}), 32'd1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_rdata", m1_rdata, 32'd0);
    check("t1_m1_gnt", 32'(m1_gnt), 32'd0);
    after_edge();
    bus_gnt = 1'b1;
    @(negedge clk);
    check("t1_stray_idle", 32'({m1_data_gnt, m1_gnt, m0_data_gnt, m0_gnt}), 32'd0);
    check("t1_stray_rdata", m0_rdata, 32'd0);
    check("t1_stray_bus_req", 32'(bus_req), 32'd0);
    after_edge();
    bus_gnt = 1'b0; bus_data_gnt = 1'b0; bus_rdata = '0;
    @(negedge clk);
    check("t1_stay_idle", 32'(bus_req), 32'd0);

    // m1 write with bus_gnt delayed four cycles; stray data_gnt during ADDR
    after_edge();
    m1_req = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'b0001;
    after_edge();
    for (int i = 0; i < 4; i++) begin
      bus_gnt      = (i == 3);
      bus_data_gnt = (i == 0);
      @(negedge clk);
      check("t2_bus_req", 32'(bus_req), 32'd1);
      check("t2_bus_addr", bus_addr, 32'h200);
      check("t2_bus_wdata", bus_wdata, 32'h12345678);
      check("t2_bus_wstrb", 32'(bus_wstrb), 32'd1);
      check("t2_gnt", 32'({m1_gnt, m0_gnt}), (i == 3) ? 32'd2 : 32'd0);
      check("t2_no_data_gnt", 32'({m1_data_gnt, m0_data_gnt}), 32'd0);
      after_edge();
    end
    bus_gnt = 1'b0; bus_data_gnt = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    check("t2_data_bus_req", 32'(bus_req), 32'd0);
    bus_data_gnt = 1'b1;
    #1;
    check("t2_data_gnt", 32'({m1_data_gnt, m0_data_gnt}), 32'd2);
    after_edge();
    bus_data_gnt = 1'b0;

    // simultaneous requests
    after_edge();
    m0_req = 1'b1; m0_addr = 32'h300;
    m1_req = 1'b1; m1_addr = 32'h400;
`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
    serve("t3_first", 1'b0, 32'h300, 1'b0);
    serve("t3_second", 1'b1, 32'h400, 1'b0);
`else
    serve("t3_first", 1'b1, 32'h400, 1'b0);
    serve("t3_second", 1'b0, 32'h300, 1'b0);
`endif

    // anrst during DATA abandons the transaction
    m0_req = 1'b1; m0_addr = 32'h500;
    after_edge();
    bus_gnt = 1'b1;
    after_edge();
    bus_gnt = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    bus_data_gnt = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    check("t4_data_gnt_live", 32'(m0_data_gnt), 32'd1);
    anrst = 1'b0;
    #1;
    check("t4_async_clear", 32'({m1_data_gnt, m0_data_gnt}), 32'd0);
    check("t4_async_rdata", m0_rdata, 32'd0);
    after_edge();
    anrst = 1'b1;
    @(negedge clk);
    check("t4_pending_ignored", 32'({m1_data_gnt, m0_data_gnt}), 32'd0);
    check("t4_idle", 32'(bus_req), 32'd0);
    after_edge();
    bus_data_gnt = 1'b0; bus_rdata = '0;
    @(negedge clk);
    check("t4_still_idle", 32'(bus_req), 32'd0);
    after_edge();
    m0_req = 1'b1; m0_addr = 32'h600;
    serve("t4_next", 1'b0, 32'h600, 1'b0);

    // nrst low on an edge clears ADDR; held request is then served afresh
    m1_req = 1'b1; m1_addr = 32'h700;
    after_edge();
    @(negedge clk);
    check("t5_addr", 32'(bus_req), 32'd1);
    nrst = 1'b0;
    after_edge();
    nrst = 1'b1;
    @(negedge clk);
    check("t5_cleared", 32'(bus_req), 32'd0);
    serve("t5_retry", 1'b1, 32'h700, 1'b0);

    // m0 requesting continuously, m1 once
    m0_req = 1'b1; m0_addr = 32'h800;
    serve("t6_m0a", 1'b0, 32'h800, 1'b1);
    m1_req = 1'b1; m1_addr = 32'h900;
    serve("t6_m1", 1'b1, 32'h900, 1'b0);
    serve("t6_m0b", 1'b0, 32'h800, 1'b0);

`ifdef LADYBIRD_ARB_ROUND_ROBIN_EN
    // m1 requesting continuously, m0 once
    m1_req = 1'b1; m1_addr = 32'hA00;
    serve("t7_m1a", 1'b1, 32'hA00, 1'b1);
    m0_req = 1'b1; m0_addr = 32'hB00;
    serve("t7_m0", 1'b0, 32'hB00, 1'b0);
    serve("t7_m1b", 1'b1, 32'hA00, 1'b0);
`endif

    repeat (2) after_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
